// File: rtl/fpga_config_loader.sv
// Serialises host config words onto the fabric CRAM scan chain and packs the bits
// leaving the far end of the chain into a readback word stream.
module fpga_config_loader #(
  parameter int WORD_WIDTH = 32,
  parameter int CHAIN_LEN  = 1024,
  parameter int CW         = $clog2(CHAIN_LEN + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [WORD_WIDTH-1:0] wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic [WORD_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic                  config_en,
  output logic                  config_bit_out,
  input  logic                  config_bit_in,
  output logic                  busy,
  output logic                  done,
  output logic [CW-1:0]         bit_count
);

  localparam int PW = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;
  localparam int LW = $clog2(WORD_WIDTH + 1);
  localparam logic [CW-1:0] LAST_IDX  = CW'(CHAIN_LEN - 1);
  localparam logic [PW-1:0] POS_TOP   = PW'(WORD_WIDTH - 1);
  localparam logic [LW-1:0] LEFT_FULL = LW'(WORD_WIDTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [WORD_WIDTH-1:0] in_q, in_d;
  logic [LW-1:0]         in_left_q, in_left_d;
  logic [CW-1:0]         bit_count_q, bit_count_d;
  logic [WORD_WIDTH-1:0] asm_q, asm_d;
  logic [PW-1:0]         asm_pos_q, asm_pos_d;
  logic [WORD_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  done_q, done_d;

  logic                  in_valid;
  logic                  last_bit;
  logic                  word_end;
  logic                  rd_free;
  logic                  shift_en;
  logic                  wr_ready_int;
  logic                  wr_hs;
  logic                  load_start;
  logic                  drop;
  logic                  flush_done;
  logic [WORD_WIDTH-1:0] cap_word;

  assign in_valid = (in_left_q != '0);
  assign last_bit = (bit_count_q == LAST_IDX);
  // A bit that completes a readback word needs somewhere to put that word.
  assign word_end = (asm_pos_q == POS_TOP) || last_bit;
  assign rd_free  = !rd_valid_q || rd_ready;
  assign shift_en = (state_q == S_SHIFT) && !abort && in_valid && (!word_end || rd_free);

  assign wr_ready_int = (state_q == S_SHIFT) && !abort &&
                        (!in_valid || (shift_en && (in_left_q == LW'(1))));
  assign wr_hs        = wr_valid && wr_ready_int;

  assign load_start = (state_q == S_IDLE) && start && !abort;
  assign drop       = (state_q != S_IDLE) && abort;
  assign flush_done = (state_q == S_FLUSH) && !abort && rd_valid_q && rd_ready;

  always_comb begin
    cap_word            = asm_q;
    cap_word[asm_pos_q] = config_bit_in;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start && !abort) state_d = S_SHIFT;
      end
      S_SHIFT: begin
        if (abort)                    state_d = S_IDLE;
        else if (shift_en && last_bit) state_d = S_FLUSH;
      end
      S_FLUSH: begin
        if (abort)           state_d = S_IDLE;
        else if (flush_done) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy           = (state_q == S_SHIFT);
    config_en      = shift_en;
    config_bit_out = in_q[0];
    wr_ready       = wr_ready_int;
    rd_data        = rd_data_q;
    rd_valid       = rd_valid_q;
    done           = done_q;
    bit_count      = bit_count_q;
  end

  always_comb begin
    in_d        = in_q;
    in_left_d   = in_left_q;
    bit_count_d = bit_count_q;
    asm_d       = asm_q;
    asm_pos_d   = asm_pos_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = rd_valid_q;
    done_d      = done_q;

    if (load_start) begin
      done_d      = 1'b0;
      bit_count_d = '0;
      in_d        = '0;
      in_left_d   = '0;
      asm_d       = '0;
      asm_pos_d   = '0;
      rd_data_d   = '0;
      rd_valid_d  = 1'b0;
    end else if (drop) begin
      in_d       = '0;
      in_left_d  = '0;
      asm_d      = '0;
      asm_pos_d  = '0;
      rd_data_d  = '0;
      rd_valid_d = 1'b0;
    end else begin
      if (rd_valid_q && rd_ready) rd_valid_d = 1'b0;
      if (flush_done) done_d = 1'b1;

      if (shift_en) begin
        bit_count_d = bit_count_q + CW'(1);
        in_d        = in_q >> 1;
        in_left_d   = in_left_q - LW'(1);
        if (word_end) begin
          rd_data_d  = cap_word;
          rd_valid_d = 1'b1;
          asm_d      = '0;
          asm_pos_d  = '0;
        end else begin
          asm_d     = cap_word;
          asm_pos_d = asm_pos_q + PW'(1);
        end
      end

      if (wr_hs) begin
        in_d      = wr_data;
        in_left_d = LEFT_FULL;
      end

      // Whatever remains in the input register past the chain length is discarded.
      if (shift_en && last_bit) begin
        in_d      = '0;
        in_left_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_q        <= '0;
      in_left_q   <= '0;
      bit_count_q <= '0;
      asm_q       <= '0;
      asm_pos_q   <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      in_q        <= in_d;
      in_left_q   <= in_left_d;
      bit_count_q <= bit_count_d;
      asm_q       <= asm_d;
      asm_pos_q   <= asm_pos_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      done_q      <= done_d;
    end
  end

endmodule

// File: tb/tb_fpga_config_loader.sv
// Scoreboarded bench for fpga_config_loader with a 40-bit fabric chain model.
module tb_fpga_config_loader;

  localparam int WW    = 32;
  localparam int CHAIN = 40;
  localparam int CW    = $clog2(CHAIN + 1);

  localparam logic [31:0] W1 = 32'hA5A5A5A5;
  localparam logic [31:0] W2 = 32'h0F0F0F0F;
  localparam logic [31:0] W3 = 32'h12345678;
  localparam logic [31:0] W4 = 32'hDEADBEEF;

  logic          clk = 1'b0;
  logic          rst, start, abort;
  logic [WW-1:0] wr_data;
  logic          wr_valid, wr_ready;
  logic [WW-1:0] rd_data;
  logic          rd_valid, rd_ready;
  logic          config_en, config_bit_out, config_bit_in;
  logic          busy, done;
  logic [CW-1:0] bit_count;

  logic [CHAIN-1:0] fab = '0;

  logic        cfg_q[$];
  logic [31:0] rd_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          cfg_pulses = 0;

  always #5 clk = ~clk;

  fpga_config_loader #(.WORD_WIDTH(WW), .CHAIN_LEN(CHAIN)) u_dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .config_en(config_en), .config_bit_out(config_bit_out), .config_bit_in(config_bit_in),
    .busy(busy), .done(done), .bit_count(bit_count)
  );

  // Fabric scan chain: first flop takes config_bit_out, last flop feeds back.
  assign config_bit_in = fab[CHAIN-1];
  always @(posedge clk) begin
    if (config_en) fab <= {fab[CHAIN-2:0], config_bit_out};
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Monitor: pops expected chain bits and readback words as the DUT presents them.
  initial begin
    logic        exp_b;
    logic [31:0] exp_w;
    forever begin
      @(negedge clk);
      if (!rst && config_en) begin
        cfg_pulses++;
        check("cfg_expected_pending", 32'(cfg_q.size() > 0), 32'd1);
        if (cfg_q.size() > 0) begin
          exp_b = cfg_q.pop_front();
          check("config_bit_out", 32'(config_bit_out), 32'(exp_b));
        end
      end
      if (!rst && rd_valid && rd_ready) begin
        check("rd_expected_pending", 32'(rd_q.size() > 0), 32'd1);
        if (rd_q.size() > 0) begin
          exp_w = rd_q.pop_front();
          check("rd_data", rd_data, exp_w);
        end
        $display("rd word 0x%08h accepted", rd_data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push_bits(input logic [31:0] w, input int n);
    for (int i = 0; i < n; i++) cfg_q.push_back(w[i]);
  endtask

  task automatic do_start();
    tick(); start = 1'b1;
    tick(); start = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    int n;
    n = 0;
    tick();
    wr_data  = w;
    wr_valid = 1'b1;
    @(negedge clk);
    while (!wr_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("wr_handshake", 32'(wr_ready), 32'd1);
    tick();
    wr_valid = 1'b0;
    $display("wr word 0x%08h sent", w);
  endtask

  task automatic wait_count(input int c);
    int n;
    n = 0;
    @(negedge clk);
    while (32'(bit_count) != c && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("bit_count_reached", 32'(bit_count), 32'(c));
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    @(negedge clk);
    while (!done && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("done_set", 32'(done), 32'd1);
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_config_en"}, 32'(config_en), 32'd0);
    check({tag, "_config_bit_out"}, 32'(config_bit_out), 32'd0);
    check({tag, "_wr_ready"}, 32'(wr_ready), 32'd0);
    check({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
    check({tag, "_rd_data"}, rd_data, 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_bit_count"}, 32'(bit_count), 32'd0);
  endtask

  initial begin
    int base;
    int viol;
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    wr_data = '0; wr_valid = 1'b0; rd_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_idle_zero("reset");

    // Load 1: fabric starts cleared, so both readback words are zero.
    push_bits(W1, 32); push_bits(W2, 8);
    rd_q.push_back(32'h0); rd_q.push_back(32'h0);
    base = cfg_pulses;
    do_start();
    check("busy_after_start", 32'(busy), 32'd1);
    send_word(W1);
    check("first_config_en_latency", 32'(config_en), 32'd1);
    send_word(W2);
    wait_done();
    check("load1_bit_count", 32'(bit_count), 32'd40);
    check("load1_busy", 32'(busy), 32'd0);
    check("load1_pulses", 32'(cfg_pulses - base), 32'd40);

    // Load 2: host stalls between words; readback returns load 1 content.
    push_bits(W1, 32); push_bits(W2, 8);
    rd_q.push_back(32'hA5A5A5A5); rd_q.push_back(32'h0000000F);
    base = cfg_pulses;
    do_start();
    check("load2_done_cleared", 32'(done), 32'd0);
    send_word(W1);
    wait_count(32);
    viol = 0;
    repeat (5) begin
      @(negedge clk);
      if (config_en !== 1'b0 || 32'(bit_count) != 32) viol++;
    end
    check("host_stall_hold", 32'(viol), 32'd0);
    send_word(W2);
    wait_done();
    check("load2_pulses", 32'(cfg_pulses - base), 32'd40);

    // Load 3: consumer stalls; chain halts when the final word cannot be handed off.
    tick(); rd_ready = 1'b0;
    push_bits(W3, 32); push_bits(W4, 8);
    rd_q.push_back(32'hA5A5A5A5); rd_q.push_back(32'h0000000F);
    base = cfg_pulses;
    do_start();
    send_word(W3);
    send_word(W4);
    wait_count(39);
    viol = 0;
    repeat (40) begin
      @(negedge clk);
      if (config_en !== 1'b0 || 32'(bit_count) != 39 ||
          rd_valid !== 1'b1 || rd_data !== 32'hA5A5A5A5) viol++;
    end
    check("rd_stall_hold", 32'(viol), 32'd0);
    check("rd_stall_data", rd_data, 32'hA5A5A5A5);
    tick(); rd_ready = 1'b1;
    wait_done();
    check("load3_pulses", 32'(cfg_pulses - base), 32'd40);

    // Load 4: abort after 17 bits.
    push_bits(32'hFFFFFFFF, 32);
    base = cfg_pulses;
    do_start();
    send_word(32'hFFFFFFFF);
    wait_count(16);
    tick(); abort = 1'b1;
    tick(); abort = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_config_en", 32'(config_en), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_rd_valid", 32'(rd_valid), 32'd0);
    check("abort_bit_count", 32'(bit_count), 32'd17);
    check("abort_pulses", 32'(cfg_pulses - base), 32'd17);
    check("abort_leftover_bits", 32'(cfg_q.size()), 32'd15);
    cfg_q.delete();

    // start and abort together in IDLE: abort wins.
    tick(); start = 1'b1; abort = 1'b1;
    tick(); start = 1'b0; abort = 1'b0;
    check("start_abort_busy", 32'(busy), 32'd0);
    check("start_abort_wr_ready", 32'(wr_ready), 32'd0);

    // Load 5: start while shifting is ignored, then reset mid-load.
    push_bits(32'h3C3C3C3C, 32);
    do_start();
    send_word(32'h3C3C3C3C);
    wait_count(5);
    tick(); start = 1'b1;
    tick(); start = 1'b0;
    check("start_ignored_bit_count", 32'(bit_count), 32'd7);
    check("start_ignored_busy", 32'(busy), 32'd1);
    wait_count(10);
    tick(); rst = 1'b1;
    tick();
    check_idle_zero("midload_rst");
    rst = 1'b0;
    cfg_q.delete();

    tick();
    check("rd_queue_drained", 32'(rd_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
